// File: rtl/sblk_row_inst_sched.sv
// Per-row instruction scheduler for a row of superblocks: buffers one instruction
// per row, issues it once the row is idle, and supports a drain barrier.
module sblk_row_inst_sched #(
    parameter int N_ROW      = 6,
    parameter int WID_INST   = 14,
    parameter int STATUS_LAT = 2,
    parameter int WID_CNT    = 16
) (
    input  logic                      clk_l,
    input  logic                      rst,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic                      cmd_barrier,
    input  logic [N_ROW-1:0]          cmd_mask,
    input  logic [WID_INST-1:0]       cmd_inst,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic [N_ROW-1:0]          row_idle,
    output logic                      all_idle,
    output logic [WID_CNT-1:0]        issue_cnt
);

    typedef enum logic {ACCEPT, BAR_WAIT} state_t;

    state_t              state;
    logic [N_ROW-1:0]    pend;
    logic [WID_INST-1:0] pdat [N_ROW];
    logic [2:0]          hold_cnt [N_ROW];
    logic [N_ROW-1:0]    elig;
    logic                accept;

    function automatic logic [WID_CNT-1:0] popcount(input logic [N_ROW-1:0] v);
        logic [WID_CNT-1:0] sum;
        sum = '0;
        for (int i = 0; i < N_ROW; i++) begin
            sum = sum + WID_CNT'(v[i]);
        end
        return sum;
    endfunction

    always_comb begin
        elig     = '0;
        row_idle = '0;
        for (int r = 0; r < N_ROW; r++) begin
            elig[r]     = pend[r] && (hold_cnt[r] == 3'd0) && !status_sblk[r];
            row_idle[r] = !pend[r] && (hold_cnt[r] == 3'd0) && !status_sblk[r] && !inst_en[r];
        end
    end

    // A busy row never blocks acceptance; only an occupied pending slot does.
    always_comb begin
        cmd_rdy = 1'b0;
        if (!rst && state == ACCEPT) begin
            cmd_rdy = cmd_barrier || ((cmd_mask & pend) == '0);
        end
    end

    assign accept   = cmd_vld && cmd_rdy;
    assign all_idle = (&row_idle) && (state == ACCEPT);

    always_ff @(posedge clk_l) begin
        if (rst) begin
            state     <= ACCEPT;
            pend      <= '0;
            inst_en   <= '0;
            inst_data <= '0;
            issue_cnt <= '0;
            for (int r = 0; r < N_ROW; r++) begin
                pdat[r]     <= '0;
                hold_cnt[r] <= '0;
            end
        end else begin
            issue_cnt <= issue_cnt + popcount(inst_en);

            case (state)
                ACCEPT:   if (accept && cmd_barrier) state <= BAR_WAIT;
                BAR_WAIT: if (&row_idle) state <= ACCEPT;
                default:  state <= ACCEPT;
            endcase

            for (int r = 0; r < N_ROW; r++) begin
                if (elig[r]) begin
                    inst_en[r]                          <= 1'b1;
                    inst_data[r*WID_INST +: WID_INST]   <= pdat[r];
                    pend[r]                             <= 1'b0;
                    hold_cnt[r]                         <= 3'(STATUS_LAT);
                end else begin
                    inst_en[r] <= 1'b0;
                    if (hold_cnt[r] != 3'd0) hold_cnt[r] <= hold_cnt[r] - 3'd1;
                end
                // An accept can only target a row whose slot is empty, so it never races an issue.
                if (accept && !cmd_barrier && cmd_mask[r]) begin
                    pend[r] <= 1'b1;
                    pdat[r] <= cmd_inst;
                end
            end
        end
    end

endmodule

// File: tb/tb_sblk_row_inst_sched.sv
// Directed bench for sblk_row_inst_sched with hand-computed expectations.
module tb_sblk_row_inst_sched;

    localparam int N_ROW      = 6;
    localparam int WID_INST   = 14;
    localparam int STATUS_LAT = 2;
    localparam int WID_CNT    = 16;

    logic                      clk_l;
    logic                      rst;
    logic                      cmd_vld;
    logic                      cmd_rdy;
    logic                      cmd_barrier;
    logic [N_ROW-1:0]          cmd_mask;
    logic [WID_INST-1:0]       cmd_inst;
    logic [N_ROW-1:0]          status_sblk;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0]          inst_en;
    logic [N_ROW-1:0]          row_idle;
    logic                      all_idle;
    logic [WID_CNT-1:0]        issue_cnt;

    int checks = 0;
    int errors = 0;

    sblk_row_inst_sched #(
        .N_ROW(N_ROW), .WID_INST(WID_INST), .STATUS_LAT(STATUS_LAT), .WID_CNT(WID_CNT)
    ) dut (
        .clk_l(clk_l), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_barrier(cmd_barrier), .cmd_mask(cmd_mask), .cmd_inst(cmd_inst),
        .status_sblk(status_sblk), .inst_data(inst_data), .inst_en(inst_en),
        .row_idle(row_idle), .all_idle(all_idle), .issue_cnt(issue_cnt)
    );

    initial clk_l = 1'b0;
    always #5 clk_l = ~clk_l;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_l);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    function automatic logic [WID_INST-1:0] slc(input int r);
        return inst_data[r*WID_INST +: WID_INST];
    endfunction

    initial begin
        rst         = 1'b1;
        cmd_vld     = 1'b1;
        cmd_barrier = 1'b0;
        cmd_mask    = 6'h3F;
        cmd_inst    = 14'h0001;
        status_sblk = '0;

        // reset held for 3 cycles with a command offered
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk("rst_rdy", 32'(cmd_rdy), 32'h0);
            chk("rst_en", 32'(inst_en), 32'h0);
            chk("rst_cnt", 32'(issue_cnt), 32'h0);
        end
        rst     = 1'b0;
        cmd_vld = 1'b0;
        settle();
        chk("post_rst_rdy", 32'(cmd_rdy), 32'h1);
        chk("post_rst_idle", 32'(all_idle), 32'h1);

        // broadcast
        tick();
        cmd_vld  = 1'b1;
        cmd_mask = 6'h3F;
        cmd_inst = 14'h01A5;
        settle();
        chk("bc_rdy", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_vld = 1'b0;
        settle();
        chk("bc_en_t1", 32'(inst_en), 32'h0);
        tick();
        chk("bc_en_t2", 32'(inst_en), 32'h3F);
        for (int r = 0; r < N_ROW; r++) chk("bc_data", 32'(slc(r)), 32'h01A5);
        chk("bc_cnt_t2", 32'(issue_cnt), 32'h0);
        tick();
        chk("bc_en_t3", 32'(inst_en), 32'h0);
        chk("bc_cnt", 32'(issue_cnt), 32'd6);
        tick();
        tick();
        settle();
        chk("bc_idle", 32'(all_idle), 32'h1);

        // busy row 2
        status_sblk = 6'h04;
        cmd_vld     = 1'b1;
        cmd_mask    = 6'h04;
        cmd_inst    = 14'h0111;
        settle();
        chk("busy_rdy", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_mask = 6'h04;
        cmd_inst = 14'h0222;
        settle();
        chk("busy_idle2", 32'(row_idle[2]), 32'h0);
        chk("busy_en", 32'(inst_en), 32'h0);
        chk("busy_rdy2", 32'(cmd_rdy), 32'h0);
        cmd_mask = 6'h01;
        cmd_inst = 14'h00AA;
        settle();
        chk("busy_rdy0", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_vld = 1'b0;
        settle();
        chk("busy_en_a2", 32'(inst_en), 32'h0);
        tick();
        chk("busy_en_r0", 32'(inst_en), 32'h01);
        chk("busy_d0", 32'(slc(0)), 32'h00AA);
        tick();
        chk("busy_en_a4", 32'(inst_en), 32'h0);
        chk("busy_cnt", 32'(issue_cnt), 32'd7);
        status_sblk = 6'h00;
        tick();
        chk("busy_en_r2", 32'(inst_en), 32'h04);
        chk("busy_d2", 32'(slc(2)), 32'h0111);
        tick();
        chk("busy_en_off", 32'(inst_en), 32'h0);
        chk("busy_cnt2", 32'(issue_cnt), 32'd8);
        for (int i = 0; i < 4; i++) tick();

        // hold window: two commands to row 0
        cmd_vld  = 1'b1;
        cmd_mask = 6'h01;
        cmd_inst = 14'h03C3;
        settle();
        chk("hw_rdy_t0", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_inst = 14'h00F0;
        settle();
        chk("hw_rdy_t1", 32'(cmd_rdy), 32'h0);
        chk("hw_en_t1", 32'(inst_en), 32'h0);
        tick();
        chk("hw_rdy_t2", 32'(cmd_rdy), 32'h1);
        chk("hw_en_t2", 32'(inst_en), 32'h01);
        chk("hw_d_t2", 32'(slc(0)), 32'h03C3);
        tick();
        cmd_vld = 1'b0;
        chk("hw_en_t3", 32'(inst_en), 32'h0);
        tick();
        chk("hw_en_t4", 32'(inst_en), 32'h0);
        chk("hw_d_t4", 32'(slc(0)), 32'h03C3);
        tick();
        chk("hw_en_t5", 32'(inst_en), 32'h01);
        chk("hw_d_t5", 32'(slc(0)), 32'h00F0);
        for (int i = 0; i < 4; i++) tick();
        chk("hw_cnt", 32'(issue_cnt), 32'd10);

        // barrier behind a row-1 command whose sblk stays busy 10 cycles
        cmd_vld     = 1'b1;
        cmd_barrier = 1'b0;
        cmd_mask    = 6'h02;
        cmd_inst    = 14'h0155;
        settle();
        chk("bar_cmd_rdy", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_barrier = 1'b1;
        settle();
        chk("bar_rdy", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_vld     = 1'b0;
        cmd_barrier = 1'b0;
        chk("bar_en", 32'(inst_en), 32'h02);
        for (int k = 2; k <= 13; k++) begin
            status_sblk = (k >= 3 && k <= 12) ? 6'h02 : 6'h00;
            settle();
            chk("bar_wait_rdy", 32'(cmd_rdy), 32'h0);
            chk("bar_wait_idle", 32'(all_idle), 32'h0);
            tick();
        end
        chk("bar_exit_rdy", 32'(cmd_rdy), 32'h1);
        chk("bar_exit_idle", 32'(all_idle), 32'h1);
        chk("bar_cnt", 32'(issue_cnt), 32'd11);

        // no-op command
        cmd_vld  = 1'b1;
        cmd_mask = 6'h00;
        cmd_inst = 14'h3FFF;
        settle();
        chk("nop_rdy", 32'(cmd_rdy), 32'h1);
        tick();
        cmd_vld = 1'b0;
        chk("nop_en1", 32'(inst_en), 32'h0);
        tick();
        chk("nop_en2", 32'(inst_en), 32'h0);
        chk("nop_cnt", 32'(issue_cnt), 32'd11);
        chk("nop_idle", 32'(row_idle), 32'h3F);

        // reset mid-operation drops a pending instruction
        status_sblk = 6'h08;
        cmd_vld     = 1'b1;
        cmd_mask    = 6'h08;
        cmd_inst    = 14'h02AA;
        tick();
        cmd_vld = 1'b0;
        chk("mrst_pend", 32'(row_idle[3]), 32'h0);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        status_sblk = 6'h00;
        settle();
        chk("mrst_idle", 32'(row_idle), 32'h3F);
        chk("mrst_cnt", 32'(issue_cnt), 32'h0);
        chk("mrst_data", 32'(slc(0)), 32'h0);
        tick();
        chk("mrst_en1", 32'(inst_en), 32'h0);
        tick();
        chk("mrst_en2", 32'(inst_en), 32'h0);
        chk("mrst_all", 32'(all_idle), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sblk_row_inst_sched.md
Name: sblk_row_inst_sched

Overview:
- Instruction scheduler for a row of superblocks.
- Accepts a single command stream from the top-level controller. Each command carries a row mask, and the instruction is buffered per row.
- Issues the buffered instruction to each targeted superblock as a one-cycle inst_en pulse, once that row's status_sblk shows it is idle.
- Provides a barrier command that stalls the stream until every row has drained, plus idle flags and an issue counter for the host.

Parameters:
- N_ROW, 6, number of superblocks in the row.
- WID_INST, 14, instruction width (TN+TM+TP+LN+LP = 3+3+2+3+3).
- STATUS_LAT, 2, cycles after an issue during which the row's status_sblk is ignored (sblk busy-rise delay). Legal range is 1..7.
- WID_CNT, 16, width of the issue counter.

Ports:
- clk_l, in, 1: single clock. All logic is on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- cmd_vld, in, 1: command valid.
- cmd_rdy, out, 1: command ready. A command is accepted when cmd_vld && cmd_rdy.
- cmd_barrier, in, 1: command is a barrier. cmd_mask and cmd_inst are ignored.
- cmd_mask, in, N_ROW: target rows. Bit r selects row r.
- cmd_inst, in, WID_INST: instruction word.
- status_sblk, in, N_ROW: per-row busy flag from the superblocks. 1 = busy.
- inst_data, out, WID_INST*N_ROW: per-row instruction. Row r uses slice [r*WID_INST +: WID_INST].
- inst_en, out, N_ROW: per-row single-cycle issue strobe.
- row_idle, out, N_ROW: per-row idle flag.
- all_idle, out, 1: every row is idle and the scheduler is not in a barrier.
- issue_cnt, out, WID_CNT: total issued strobes, wrapping.

Behaviour:
- Reset: while rst=1, every register clears.
  - State is ACCEPT.
  - pend, hold_cnt, inst_en, inst_data and issue_cnt are all 0.
  - cmd_rdy=0 while rst=1. It may rise in the first cycle after rst falls.
  - A reset mid-operation drops all pending instructions without issuing them.
- Per-row storage, each row r has:
  - pend[r], one pending-slot flag;
  - pdat[r], WID_INST bits of pending data;
  - hold_cnt[r], 3 bits.
- States:
  - ACCEPT: normal operation.
  - BAR_WAIT: barrier in progress.
- cmd_rdy:
  - In ACCEPT with cmd_barrier=0: cmd_rdy = !rst && (cmd_mask & pend) == 0.
  - In ACCEPT with cmd_barrier=1: cmd_rdy = !rst.
  - In BAR_WAIT: cmd_rdy = 0.
  - A busy status_sblk does not block acceptance; the pending slot is the buffer.
- Non-barrier accept: for every r in cmd_mask, pend[r] <= 1 and pdat[r] <= cmd_inst.
  - cmd_mask = 0 is accepted as a no-op. It issues nothing and does not count.
- Barrier accept: state goes to BAR_WAIT.
  - Leave BAR_WAIT for ACCEPT at the first edge where every row has pend=0, hold_cnt=0, status_sblk=0 and inst_en=0.
- Issue, per row, independently:
  - Eligibility: elig[r] = pend[r] && hold_cnt[r]==0 && !status_sblk[r].
  - On the edge where elig[r] holds: inst_en[r] <= 1, inst_data slice r <= pdat[r], pend[r] <= 0, hold_cnt[r] <= STATUS_LAT.
  - Otherwise inst_en[r] <= 0, and hold_cnt[r] decrements if nonzero.
- Issue latency and throughput:
  - A command accepted in cycle t to an idle row gives inst_en visible in cycle t+2, high for exactly one cycle.
  - The earliest re-accept to the same row is cycle t+2.
  - With status held at 0, back-to-back issues to one row are STATUS_LAT+1 cycles apart.
- inst_data slices hold their last issued value and are never cleared except by reset.
- Idle flags:
  - row_idle[r] = !pend[r] && hold_cnt[r]==0 && !status_sblk[r] && !inst_en[r].
  - all_idle = &row_idle && state==ACCEPT.
  - Both are combinational from registers and status_sblk.
- issue_cnt: each cycle, issue_cnt <= issue_cnt + popcount(inst_en), modulo 2^WID_CNT.
- Simultaneous events:
  - An issue and a re-accept to the same row cannot coincide, because cmd_rdy requires pend[r]=0.
  - Different rows issue in the same cycle independently.
  - A barrier accepted while a row is still pending waits for that row to issue and drain.
- Protocol: cmd_* must be held stable while cmd_vld=1 && cmd_rdy=0. The scheduler does not check this.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cmd_vld=1 -> cmd_rdy=0, inst_en=0, issue_cnt=0 throughout. After rst falls, cmd_rdy=1 and all_idle=1.
- Broadcast: mask=6'h3F, inst=14'h1A5, status all 0, accepted at t -> inst_en=6'h3F in t+2 only. Every inst_data slice is 14'h1A5 and issue_cnt=6.
- Busy row:
  - Hold status_sblk[2]=1 and send mask=6'h04 -> no strobe, and row_idle[2]=0.
  - A second command to row 2 sees cmd_rdy=0.
  - A command to row 0 is still accepted.
  - status[2] falls at cycle u -> inst_en[2] at u+1.
- Hold window: STATUS_LAT=2, two commands to row 0 back to back, status 0 -> inst_en[0] at t+2 and t+5, with data matching each command in order.
- Barrier:
  - Send a command to row 1, then a barrier.
  - status[1] rises 1 cycle after its issue and stays high 10 cycles.
  - Expect cmd_rdy=0 until the cycle after status[1] falls with all rows drained, then ACCEPT; all_idle=0 during BAR_WAIT.
- No-op: mask=0, non-barrier -> accepted in 1 cycle, inst_en stays 0 and issue_cnt is unchanged.
